// File: rtl/char_display_pkg.sv
// Shared constants for the character display path: display ids, sprite geometry
// and the see-through colour, plus a helper that folds unknown ids onto id 0.
package char_display_pkg;

  localparam logic [2:0] IDLE_DIS_1         = 3'd0;
  localparam logic [2:0] IDLE_DIS_2         = 3'd1;
  localparam logic [2:0] CHARGE_DIS         = 3'd2;
  localparam logic [2:0] JUMP_UP_DIS        = 3'd3;
  localparam logic [2:0] JUMP_DOWN_DIS      = 3'd4;
  localparam logic [2:0] FALL_TO_GROUND_DIS = 3'd5;
  localparam logic [2:0] SAFE_GROUND_DIS    = 3'd6;

  localparam int          NUM_SPRITES       = 7;
  localparam int          SPRITE_W          = 32;
  localparam int          SPRITE_H          = 32;
  localparam logic [11:0] TRANSPARENT_COLOR = 12'hF0F;

  // Ids with no sprite stored in the ROM fall back to the first idle frame.
  function automatic logic [2:0] clamp_id(input logic [2:0] id, input int n);
    return (int'(id) >= n) ? IDLE_DIS_1 : id;
  endfunction

endpackage

// File: rtl/sprite_hit_calc.sv
// Stage 0 sprite-relative offset and hit test, stage 1 ROM address register.
// Horizontal flip is compiled in with CHAR_SPRITE_MIRROR_EN.
module sprite_hit_calc #(
  parameter int CW             = 10,
  parameter int SPRITE_W       = 32,
  parameter int SPRITE_H       = 32,
  parameter int ROM_ADDR_WIDTH = 13
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pix_valid,
  input  logic [CW-1:0]             pix_x,
  input  logic [CW-1:0]             pix_y,
  input  logic [CW-1:0]             pos_x,
  input  logic [CW-1:0]             pos_y,
  input  logic [2:0]                id,
  input  logic                      face_left,
  output logic                      hit,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr
);

  localparam int XW = $clog2(SPRITE_W);
  localparam int YW = $clog2(SPRITE_H);
  localparam logic signed [CW:0] SW = (CW+1)'(SPRITE_W);
  localparam logic signed [CW:0] SH = (CW+1)'(SPRITE_H);

  logic signed [CW:0]        dx, dy;
  logic [XW-1:0]             col;
  logic [ROM_ADDR_WIDTH-1:0] addr_next;

  // Zero-extended subtraction: no wrap, so sprites past the right/bottom edge clip.
  assign dx  = $signed({1'b0, pix_x}) - $signed({1'b0, pos_x});
  assign dy  = $signed({1'b0, pix_y}) - $signed({1'b0, pos_y});
  assign hit = !dx[CW] && (dx < SW) && !dy[CW] && (dy < SH);

`ifdef CHAR_SPRITE_MIRROR_EN
  // SPRITE_W is a power of two, so SPRITE_W-1-dx is the bitwise complement.
  assign col = face_left ? ~dx[XW-1:0] : dx[XW-1:0];
`else
  logic unused_face;
  assign unused_face = face_left;
  assign col = dx[XW-1:0];
`endif

  assign addr_next = ROM_ADDR_WIDTH'(id) * ROM_ADDR_WIDTH'(SPRITE_W * SPRITE_H)
                   + ROM_ADDR_WIDTH'({dy[YW-1:0], col});

  always_ff @(posedge clk) begin
    if (rst)                   rom_addr <= '0;
    else if (pix_valid && hit) rom_addr <= addr_next;
  end

endmodule

// File: rtl/character_sprite_renderer.sv
// Renders the current character sprite onto the VGA scan: per-frame shadow latch,
// 3-cycle ROM pipeline, opaque pixel counter. Optional flip: CHAR_SPRITE_MIRROR_EN.
module character_sprite_renderer #(
  parameter int SCREEN_COORD_WIDTH = 10,
  parameter int SPRITE_W           = char_display_pkg::SPRITE_W,
  parameter int SPRITE_H           = char_display_pkg::SPRITE_H,
  parameter int NUM_SPRITES        = char_display_pkg::NUM_SPRITES,
  parameter int PIXEL_WIDTH        = 12,
  parameter logic [PIXEL_WIDTH-1:0] TRANSPARENT_COLOR = char_display_pkg::TRANSPARENT_COLOR,
  parameter int ROM_ADDR_WIDTH     = $clog2(NUM_SPRITES * SPRITE_W * SPRITE_H),
  parameter int CNT_WIDTH          = $clog2(SPRITE_W * SPRITE_H + 1)
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          frame_start,
  input  logic                          pix_valid,
  input  logic [SCREEN_COORD_WIDTH-1:0] pix_x,
  input  logic [SCREEN_COORD_WIDTH-1:0] pix_y,
  input  logic [SCREEN_COORD_WIDTH-1:0] char_pos_x,
  input  logic [SCREEN_COORD_WIDTH-1:0] char_pos_y,
  input  logic [2:0]                    char_display_id,
  input  logic                          char_face_left,
  output logic [ROM_ADDR_WIDTH-1:0]     rom_addr,
  input  logic [PIXEL_WIDTH-1:0]        rom_data,
  output logic                          out_valid,
  output logic [PIXEL_WIDTH-1:0]        out_pixel,
  output logic                          out_opaque,
  output logic [CNT_WIDTH-1:0]          frame_opaque_cnt
);

  logic [SCREEN_COORD_WIDTH-1:0] pos_x_l, pos_y_l;
  logic [2:0]                    id_l;
  logic                          face_l;
  logic                          hit;
  logic [2:1]                    vld_pipe, hit_pipe;
  logic                          opaque_next;
  logic [CNT_WIDTH-1:0]          acc;

  // Shadows change only at frame_start so the sprite never tears mid-frame.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pos_x_l <= '0;
      pos_y_l <= '0;
      id_l    <= '0;
      face_l  <= 1'b0;
    end else if (frame_start) begin
      pos_x_l <= char_pos_x;
      pos_y_l <= char_pos_y;
      id_l    <= char_display_pkg::clamp_id(char_display_id, NUM_SPRITES);
      face_l  <= char_face_left;
    end
  end

  sprite_hit_calc #(
    .CW             (SCREEN_COORD_WIDTH),
    .SPRITE_W       (SPRITE_W),
    .SPRITE_H       (SPRITE_H),
    .ROM_ADDR_WIDTH (ROM_ADDR_WIDTH)
  ) u_hit (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .pix_valid (pix_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pos_x     (pos_x_l),
    .pos_y     (pos_y_l),
    .id        (id_l),
    .face_left (face_l),
    .hit       (hit),
    .rom_addr  (rom_addr)
  );

  assign opaque_next = vld_pipe[2] && hit_pipe[2] && (rom_data != TRANSPARENT_COLOR);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      vld_pipe   <= '0;
      hit_pipe   <= '0;
      out_valid  <= 1'b0;
      out_opaque <= 1'b0;
      out_pixel  <= '0;
    end else begin
      vld_pipe   <= {vld_pipe[1], pix_valid};
      hit_pipe   <= {hit_pipe[1], hit};
      out_valid  <= vld_pipe[2];
      out_opaque <= opaque_next;
      out_pixel  <= opaque_next ? rom_data : '0;
    end
  end

  // A pixel landing on the frame_start cycle belongs to the new frame.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      acc              <= '0;
      frame_opaque_cnt <= '0;
    end else if (frame_start) begin
      frame_opaque_cnt <= acc;
      acc              <= CNT_WIDTH'(out_opaque);
    end else if (out_opaque && acc != '1) begin
      acc <= acc + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_character_sprite_renderer.sv
// Randomized bench for character_sprite_renderer with a behavioural pixel model
// and a simple synchronous ROM model.
module tb_character_sprite_renderer;

  localparam int          AW  = 13;
  localparam int          CWD = 11;
  localparam logic [11:0] TC  = 12'hF0F;

  logic          sys_clk = 1'b0;
  logic          sys_rst, frame_start, pix_valid, char_face_left;
  logic [9:0]    pix_x, pix_y, char_pos_x, char_pos_y;
  logic [2:0]    char_display_id;
  logic [AW-1:0] rom_addr;
  logic [11:0]   rom_data, out_pixel;
  logic          out_valid, out_opaque;
  logic [CWD-1:0] frame_opaque_cnt;

  always #5 sys_clk = ~sys_clk;

  character_sprite_renderer dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .frame_start(frame_start),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .char_pos_x(char_pos_x), .char_pos_y(char_pos_y),
    .char_display_id(char_display_id), .char_face_left(char_face_left),
    .rom_addr(rom_addr), .rom_data(rom_data), .out_valid(out_valid),
    .out_pixel(out_pixel), .out_opaque(out_opaque),
    .frame_opaque_cnt(frame_opaque_cnt)
  );

  logic [11:0] rom [0:7167];
  always @(posedge sys_clk) rom_data <= rom[int'(rom_addr)];

  // Reference model: what the renderer should show, derived from the scan position.
  typedef struct packed { logic v; logic o; logic [11:0] p; } ent_t;
  int   sx, sy, sid, m_acc, m_cnt, m_addr;
  bit   sface, last_hit;
  ent_t p0, p1, ex;
  int   n_cmp = 0, n_fail = 0;

  task automatic drive(input bit r, input bit fs, input bit pv, input int px, input int py);
    int dx, dy, col, a;
    bit h;
    ent_t e;
    sys_rst = r; frame_start = fs; pix_valid = pv;
    pix_x = 10'(px); pix_y = 10'(py);
    dx = px - sx; dy = py - sy;
    h = pv && dx >= 0 && dx < 32 && dy >= 0 && dy < 32;
    col = dx;
`ifdef CHAR_SPRITE_MIRROR_EN
    if (sface) col = 31 - dx;
`endif
    a = sid * 1024 + dy * 32 + col;
    e = '0; e.v = pv;
    if (h && rom[a] != TC) begin e.o = 1'b1; e.p = rom[a]; end
    @(posedge sys_clk); #1;
    last_hit = h && !r;
    if (r) begin
      sx = 0; sy = 0; sid = 0; sface = 0; m_acc = 0; m_cnt = 0; m_addr = 0;
      p0 = '0; p1 = '0; ex = '0;
    end else begin
      if (fs) begin
        m_cnt = m_acc; m_acc = ex.o ? 1 : 0;
        sx = int'(char_pos_x); sy = int'(char_pos_y);
        sid = (char_display_id >= 3'd7) ? 0 : int'(char_display_id);
        sface = char_face_left;
      end else if (ex.o && m_acc != 2047) m_acc++;
      if (h) m_addr = a;
      ex = p1; p1 = p0; p0 = e;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0);
  endtask

  task automatic set_char(input int x, input int y, input int id, input bit fl);
    char_pos_x = 10'(x); char_pos_y = 10'(y); char_display_id = 3'(id); char_face_left = fl;
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 7168; i++)
      rom[i] = ($urandom_range(3) == 0) ? TC : 12'($urandom_range(4095));
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0);
    drive(1, 1, 1, 5, 5);
    n_cmp++;
    if ({out_valid, out_opaque, out_pixel} !== 14'd0) begin
      n_fail++; $display("FAIL reset_out got %b/%b/%h want 0/0/000", out_valid, out_opaque, out_pixel);
    end
    n_cmp++;
    if (rom_addr !== '0 || frame_opaque_cnt !== '0) begin
      n_fail++; $display("FAIL reset_regs got addr=%0d cnt=%0d want 0/0", rom_addr, frame_opaque_cnt);
    end
    drive(0, 0, 1, 3, 3);
    drive(0, 0, 0, 0, 0);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_lat2 got out_valid=%b want 0", out_valid);
    end
    drive(0, 0, 0, 0, 0);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL reset_lat3 got out_valid=%b want 1", out_valid);
    end
  endtask

  task automatic test_latch_timing();
    fill_rom(); idle(3);
    set_char(100, 50, 2, 0);
    drive(0, 1, 1, 100, 50);   // same-cycle pixel sees the old shadows
    n_cmp++;
    if (last_hit !== 1'b0 || rom_addr !== AW'(m_addr)) begin
      n_fail++; $display("FAIL latch_old_shadow got addr=%0d want %0d", rom_addr, m_addr);
    end
    drive(0, 0, 1, 100, 50);
    n_cmp++;
    if (rom_addr !== 13'd2048) begin
      n_fail++; $display("FAIL first_hit_addr got %0d want 2048", rom_addr);
    end
    for (int y = 46; y < 86; y++)
      for (int x = 96; x < 136; x++) begin
        drive(0, 0, $urandom_range(7) != 0, x, y);
        n_cmp++;
        if ({out_valid, out_opaque, out_pixel} !== ex || rom_addr !== AW'(m_addr)) begin
          n_fail++;
          $display("FAIL latch_scan at (%0d,%0d) got v/o/p/a=%b/%b/%h/%0d want %b/%b/%h/%0d",
                   x, y, out_valid, out_opaque, out_pixel, rom_addr, ex.v, ex.o, ex.p, m_addr);
        end
      end
  endtask

  task automatic test_transparency();
    idle(3);
    for (int i = 2048; i < 3072; i++) rom[i] = TC;
    rom[2048 + 3*32 + 5] = 12'h0A0;
    for (int y = 50; y < 58; y++)
      for (int x = 98; x < 140; x++) begin
        drive(0, 0, 1, x, y);
        n_cmp++;
        if ({out_valid, out_opaque, out_pixel} !== ex) begin
          n_fail++; $display("FAIL transp_scan at (%0d,%0d) got %b/%b/%h want %b/%b/%h",
                             x, y, out_valid, out_opaque, out_pixel, ex.v, ex.o, ex.p);
        end
      end
    drive(0, 0, 1, 105, 53); idle(2);
    n_cmp++;
    if (out_opaque !== 1'b1 || out_pixel !== 12'h0A0) begin
      n_fail++; $display("FAIL opaque_pixel got %b/%h want 1/0a0", out_opaque, out_pixel);
    end
    drive(0, 0, 1, 104, 53); idle(2);
    n_cmp++;
    if (out_valid !== 1'b1 || out_opaque !== 1'b0 || out_pixel !== 12'h000) begin
      n_fail++; $display("FAIL transparent_pixel got %b/%b/%h want 1/0/000", out_valid, out_opaque, out_pixel);
    end
  endtask

  task automatic test_clip_invalid_id();
    int x;
    fill_rom(); idle(3);
    set_char(630, 470, $urandom_range(6), 0);
    drive(0, 1, 0, 0, 0);
    for (int y = 465; y < 486; y++)
      for (int i = 0; i < 42; i++) begin
        x = (i < 20) ? 620 + i : i - 20;
        drive(0, 0, 1, x, (y < 480) ? y : y - 480);
        n_cmp++;
        if ({out_valid, out_opaque, out_pixel} !== ex || rom_addr !== AW'(m_addr)) begin
          n_fail++; $display("FAIL clip_scan at (%0d,%0d) got %b/%b/%h/%0d want %b/%b/%h/%0d",
                             x, y, out_valid, out_opaque, out_pixel, rom_addr, ex.v, ex.o, ex.p, m_addr);
        end
      end
    idle(3);
    set_char(10, 10, 7, 0);
    drive(0, 1, 0, 0, 0);
    for (int k = 0; k < 600; k++) begin
      drive(0, 0, 1, $urandom_range(5, 45), $urandom_range(5, 45));
      n_cmp++;
      if ((last_hit && rom_addr >= 13'd1024) || rom_addr !== AW'(m_addr) ||
          {out_valid, out_opaque, out_pixel} !== ex) begin
        n_fail++; $display("FAIL bad_id got addr=%0d o=%b p=%h want addr=%0d o=%b p=%h",
                           rom_addr, out_opaque, out_pixel, m_addr, ex.o, ex.p);
      end
    end
  endtask

  task automatic test_midframe_count();
    idle(3);
    for (int i = 3072; i < 4096; i++) rom[i] = 12'($urandom_range(255));
    set_char(200, 100, 3, 0);
    drive(0, 1, 0, 0, 0);
    for (int y = 100; y < 132; y++) begin
      if (y == 110) char_display_id = 3'd5;
      for (int x = 198; x < 234; x++) begin
        drive(0, 0, 1, x, y);
        n_cmp++;
        if ((last_hit && rom_addr[12:10] !== 3'd3) || rom_addr !== AW'(m_addr) ||
            {out_valid, out_opaque, out_pixel} !== ex) begin
          n_fail++; $display("FAIL midframe at (%0d,%0d) got addr=%0d o=%b want addr=%0d o=%b",
                             x, y, rom_addr, out_opaque, m_addr, ex.o);
        end
      end
    end
    idle(3);
    drive(0, 1, 0, 0, 0);
    n_cmp++;
    if (frame_opaque_cnt !== 11'd1024) begin
      n_fail++; $display("FAIL full_count got %0d want 1024", frame_opaque_cnt);
    end
  endtask

  task automatic test_reset_coincident();
    idle(3);
    for (int i = 1024; i < 2048; i++) rom[i] = 12'($urandom_range(255));
    set_char(300, 200, 1, 0);
    drive(0, 1, 0, 0, 0);
    for (int x = 300; x < 310; x++) drive(0, 0, 1, x, 205);
    drive(1, 0, 1, 310, 205);
    n_cmp++;
    if (out_valid !== 1'b0 || out_opaque !== 1'b0 || frame_opaque_cnt !== '0) begin
      n_fail++; $display("FAIL mid_reset got v=%b o=%b cnt=%0d want 0/0/0", out_valid, out_opaque, frame_opaque_cnt);
    end
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 1, 305, 205); idle(2);
    n_cmp++;
    if (out_opaque !== 1'b1) begin
      n_fail++; $display("FAIL coinc_setup got out_opaque=%b want 1", out_opaque);
    end
    drive(0, 1, 0, 0, 0);
    n_cmp++;
    if (frame_opaque_cnt !== 11'd0) begin
      n_fail++; $display("FAIL coinc_old_frame got %0d want 0", frame_opaque_cnt);
    end
    idle(2);
    drive(0, 1, 0, 0, 0);
    n_cmp++;
    if (frame_opaque_cnt !== 11'd1) begin
      n_fail++; $display("FAIL coinc_new_frame got %0d want 1", frame_opaque_cnt);
    end
  endtask

  task automatic test_mirror();
    logic [AW-1:0] a0, a31;
`ifdef CHAR_SPRITE_MIRROR_EN
    a0 = 13'd31; a31 = 13'd0;
`else
    a0 = 13'd0;  a31 = 13'd31;
`endif
    fill_rom(); idle(3);
    set_char(300, 300, 0, 1);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 1, 300, 300);
    n_cmp++;
    if (rom_addr !== a0) begin
      n_fail++; $display("FAIL mirror_dx0 got %0d want %0d", rom_addr, a0);
    end
    drive(0, 0, 1, 331, 300);
    n_cmp++;
    if (rom_addr !== a31) begin
      n_fail++; $display("FAIL mirror_dx31 got %0d want %0d", rom_addr, a31);
    end
  endtask

  task automatic test_random();
    int bx, by;
    for (int f = 0; f < 20; f++) begin
      bx = $urandom_range(0, 660); by = $urandom_range(0, 500);
      set_char(bx, by, $urandom_range(7), $urandom_range(1));
      drive(0, 1, $urandom_range(1), bx, by);
      for (int k = 0; k < 250; k++) begin
        if ($urandom_range(30) == 0)
          set_char($urandom_range(0, 660), $urandom_range(0, 500), $urandom_range(7), $urandom_range(1));
        drive(0, $urandom_range(99) == 0, $urandom_range(5) != 0,
              (bx + $urandom_range(0, 80) + 984) % 1024, (by + $urandom_range(0, 80) + 984) % 1024);
        n_cmp++;
        if ({out_valid, out_opaque, out_pixel} !== ex || rom_addr !== AW'(m_addr) ||
            frame_opaque_cnt !== CWD'(m_cnt)) begin
          n_fail++; $display("FAIL random f=%0d k=%0d got %b/%b/%h/%0d/%0d want %b/%b/%h/%0d/%0d",
                             f, k, out_valid, out_opaque, out_pixel, rom_addr, frame_opaque_cnt,
                             ex.v, ex.o, ex.p, m_addr, m_cnt);
        end
      end
    end
  endtask

  initial begin
    sys_rst = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; pix_x = '0; pix_y = '0;
    set_char(0, 0, 0, 0);
    fill_rom();
    test_reset();
    test_latch_timing();
    test_transparency();
    test_clip_invalid_id();
    test_midframe_count();
    test_reset_coincident();
    test_mirror();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/character_sprite_renderer.md
Name: character_sprite_renderer

Overview:
- Consumer of the character display id produced by the character display state controller.
- Maps the VGA scan position onto the current character sprite, producing:
  - the sprite ROM address, and
  - a pixel/opaque pair for the screen compositor three cycles later.
- Position and display id are latched once per frame to prevent mid-frame tearing.
- Counts the opaque pixels drawn per frame, for collision/debug readout.

Parameters:
- SCREEN_COORD_WIDTH, 10, width of pix_x/pix_y/char_pos_x/char_pos_y.
- SPRITE_W, 32, sprite width in pixels (power of two).
- SPRITE_H, 32, sprite height in pixels (power of two).
- NUM_SPRITES, 7, number of display ids stored in the ROM (ids 0..6).
- PIXEL_WIDTH, 12, RGB444 pixel width.
- TRANSPARENT_COLOR, 12'hF0F, ROM colour treated as see-through.
- ROM_ADDR_WIDTH, $clog2(NUM_SPRITES*SPRITE_W*SPRITE_H), sprite ROM address width.
- CNT_WIDTH, $clog2(SPRITE_W*SPRITE_H+1), opaque counter width.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  synchronous active-high reset.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- pix_valid  in  1  pix_x/pix_y are inside the active area this cycle.
- pix_x  in  SCREEN_COORD_WIDTH  scan column.
- pix_y  in  SCREEN_COORD_WIDTH  scan row.
- char_pos_x  in  SCREEN_COORD_WIDTH  sprite top-left column.
- char_pos_y  in  SCREEN_COORD_WIDTH  sprite top-left row.
- char_display_id  in  3  display id from the display state controller.
- char_face_left  in  1  character faces left.
- rom_addr  out  ROM_ADDR_WIDTH  address to the synchronous sprite ROM (1-cycle read).
- rom_data  in  PIXEL_WIDTH  ROM read data, valid one cycle after rom_addr.
- out_valid  out  1  out_pixel/out_opaque valid.
- out_pixel  out  PIXEL_WIDTH  sprite colour; 0 when not opaque.
- out_opaque  out  1  compositor must draw out_pixel over the background.
- frame_opaque_cnt  out  CNT_WIDTH  opaque pixel count of the previous frame.

Behaviour:
- Reset (sys_rst=1 at a sys_clk edge):
  - All latches, pipeline valids and outputs go to 0.
  - rom_addr=0, frame_opaque_cnt=0.
  - Reset mid-frame drops in-flight pixels; no out_valid until 3 cycles after the first pix_valid following reset.
- Frame latch:
  - On frame_start, capture char_pos_x/y, char_display_id and char_face_left into shadow registers.
  - Values take effect from the next cycle; a pix_valid in the same cycle uses the old shadows.
  - If the latched id is >= NUM_SPRITES, use id 0.
- Stage 0 (cycle N, pix_valid=1):
  - dx = pix_x - pos_x_l and dy = pix_y - pos_y_l, each SCREEN_COORD_WIDTH+1 bits signed.
  - hit = dx>=0 && dx<SPRITE_W && dy>=0 && dy<SPRITE_H.
  - No wrap-around: a sprite partly off the right or bottom edge is clipped.
- Stage 1 (cycle N+1, registered):
  - rom_addr = id*SPRITE_W*SPRITE_H + dy*SPRITE_W + col, with col = dx.
  - When hit=0, rom_addr holds its previous value.
  - valid1 <= pix_valid; hit1 <= hit.
- Stage 2 (N+2): rom_data is valid; valid2 and hit2 are carried alongside.
- Stage 3 (N+3, registered outputs):
  - out_valid <= valid2.
  - out_opaque <= valid2 && hit2 && rom_data != TRANSPARENT_COLOR.
  - out_pixel <= out_opaque-condition ? rom_data : 0.
- Latency is exactly 3 cycles from pix_valid to out_valid. Throughput is 1 pixel/cycle. There is no back-pressure.
- Opaque counter:
  - acc increments on each out_opaque=1 and saturates at all-ones.
  - On frame_start: frame_opaque_cnt <= acc and acc <= 0.
  - If out_opaque and frame_start coincide, that pixel is counted into the new frame (acc <= 1).

Optional Feature:
- Macro: CHAR_SPRITE_MIRROR_EN.
- Defined: when the latched face_left=1, col = SPRITE_W-1-dx (horizontal flip).
- Not defined: char_face_left is ignored and col = dx always.

Decomposition:
- Shared package, char_display_pkg:
  - display id constants IDLE_DIS_1=0, IDLE_DIS_2=1, CHARGE_DIS=2, JUMP_UP_DIS=3, JUMP_DOWN_DIS=4, FALL_TO_GROUND_DIS=5, SAFE_GROUND_DIS=6;
  - NUM_SPRITES;
  - SPRITE_W/H;
  - TRANSPARENT_COLOR.
- One sub-module, sprite_hit_calc: stage-0 dx/dy/hit/col combinational logic plus the stage-1 address register.
- The ROM itself is external.

Test Plan:
1. Shadow latch timing:
   - Stimulus: pos=(100,50), id=2, frame_start, then scan the full frame.
   - Response: the first hit is at pix=(100,50) with rom_addr=2*1024+0=2048 one cycle later.
   - out_valid rises exactly 3 cycles after each pix_valid.
2. Transparency and opacity:
   - Stimulus: ROM returns 12'hF0F inside the sprite, and 12'h0A0 at sprite (dx=5, dy=3).
   - Response: out_opaque=0/out_pixel=0 on the 12'hF0F pixels.
   - Response: out_opaque=1, out_pixel=12'h0A0 at pix=(105,53).
3. Edge clipping and invalid id:
   - Stimulus: pos=(630,470) on a 640x480 area.
   - Response: only dx 0..9 and dy 0..9 ever hit, with no hit at pix_x 0..21.
   - Stimulus: id=7.
   - Response: addresses come from the id 0 range (0..1023).
4. Mid-frame update and opaque count:
   - Stimulus: change char_display_id mid-frame with no frame_start.
   - Response: rom_addr keeps the old id base until the next frame_start.
   - Stimulus: a fully opaque sprite (32x32).
   - Response: frame_opaque_cnt=1024 after the next frame_start.
5. Reset and coincident events:
   - Stimulus: assert sys_rst mid-sprite.
   - Response: out_valid/out_opaque=0 the next cycle and frame_opaque_cnt=0.
   - Stimulus: frame_start coincident with out_opaque.
   - Response: new acc=1.
6. Mirror (CHAR_SPRITE_MIRROR_EN defined):
   - Stimulus: face_left=1, pix at dx=0, dy=0, id=0.
   - Response: rom_addr=31.
   - Stimulus: the same case without the macro.
   - Response: rom_addr=0.
